iniciador_calculo: RTL and testbench
====================================

// Module: iniciador_calculo
// PURPOSE
// - Requester/master end of the inicio/fin four-phase handshake used by our calculation control FSMs.
// - Accepts a command (operand) over valid/ready, raises inicio, holds it until fin, captures the result,
//   drops inicio, waits for fin low, then presents result + status over valid/ready.
// - Sits between a sequencer/CPU-side bus and one inicio/fin calculation unit; adds timeout and latency measurement.
// PARAMETERS
// - DATA_W      8    operand width driven to the unit (dato)
// - RES_W       8    result width captured from the unit (resultado)
// - TIMEOUT_CYC 255  max cycles in REQ waiting for fin; 0 disables timeout
// - CNT_W       8    width of latency/timeout counter; TIMEOUT_CYC must fit in CNT_W
// PORTS
// - clk        in   1       clock, rising edge
// - rst        in   1       asynchronous reset, active-low
// - cmd_valid  in   1       command present
// - cmd_ready  out  1       command accepted when cmd_valid & cmd_ready
// - cmd_data   in   DATA_W  operand for the unit
// - inicio     out  1       start request to the unit (registered)
// - dato       out  DATA_W  operand to the unit; stable whole time inicio=1
// - fin        in   1       unit completion; may be combinational from unit, sampled on clk only
// - resultado  in   RES_W   unit result, valid while fin=1
// - res_valid  out  1       result/status available
// - res_ready  in   1       consumer takes result when res_valid & res_ready
// - res_data   out  RES_W   captured result (0 on timeout)
// - res_err    out  1       1 = timeout, no fin seen
// - lat_ciclos out  CNT_W   cycles inicio was high before fin sampled (saturating)
// - ocupado    out  1       1 in any state except IDLE
// BEHAVIOUR
// - Reset (rst=0, async): state IDLE; inicio=0, dato=0, res_valid=0, res_data=0, res_err=0, lat_ciclos=0, cnt=0.
//   cmd_ready=0 while rst=0. Reset mid-transaction aborts it; inicio falls immediately, no result emitted.
// - States: IDLE, REQ, ACK, DONE. All outputs registered or decoded from state only (no comb path fin->inicio).
// - IDLE: cmd_ready=1. On cmd_valid: dato<=cmd_data, cnt<=0, -> REQ (inicio=1 from next cycle).
// - REQ: inicio=1, cnt increments (saturates at 2^CNT_W-1).
//   fin=1 -> res_data<=resultado, res_err<=0, lat_ciclos<=cnt+1 (saturating), -> ACK.
//   fin=0 & TIMEOUT_CYC!=0 & cnt==TIMEOUT_CYC-1 -> res_data<=0, res_err<=1, lat_ciclos<=cnt+1, -> ACK.
//   fin and timeout in same cycle: fin wins, res_err=0.
// - ACK: inicio=0. fin=0 -> DONE. fin=1 -> stay (unit still completing release). No timeout in ACK.
// - DONE: res_valid=1; res_data/res_err/lat_ciclos held stable. res_ready -> IDLE (res_valid=0 next cycle).
// - cmd_ready=0 in REQ/ACK/DONE: one outstanding transaction; dato never changes while inicio=1.
// - Latency: cmd accepted at edge t -> inicio=1 during t+1. fin first sampled high at f -> inicio=0 during f+1;
//   with combinational fin release, fin sampled low at f+1 -> res_valid=1 during f+2.
// - Back-to-back: earliest next cmd_ready is the cycle after res_valid&res_ready, guaranteeing >=1 cycle inicio=0
//   with fin=0 seen by unit between transactions.
// - fin=1 while IDLE/DONE: ignored (no state change).
// STRUCTURE
// - Package calc_hs_pkg: enum logic [1:0] {IDLE, REQ, ACK, DONE} ini_estado_t; shared with unit-side FSMs
//   the handshake constants (T_INICIO_MIN_BAJO=1).
// - Sub-module contador_timeout (CNT_W, TIMEOUT_CYC): clr, en -> cnt, expira; saturating.
// - Top: state register (async reset), next-state always_comb, output/capture regs.
// TESTING
// - Nominal: cmd_data=8'h2A at t; unit model asserts fin 3 cycles after inicio rise with resultado=8'h55
//   -> inicio high 3 cycles, res_data=8'h55, res_err=0, lat_ciclos=3, res_valid at f+2.
// - Backpressure: hold res_ready=0 for 5 cycles in DONE -> outputs stable, cmd_ready=0, inicio=0; then accept.
// - Timeout: TIMEOUT_CYC=4, unit never asserts fin -> inicio high exactly 4 cycles, res_err=1, res_data=0, lat_ciclos=4.
// - Slow release: unit keeps fin=1 for 3 cycles after inicio falls -> stays ACK, res_valid 1 cycle after fin drops.
// - Async reset asserted mid-REQ -> inicio=0 same cycle (before next edge), ocupado=0, no res_valid after release.
// - Back-to-back: two cmds (0x01, 0x02), res_ready=1 -> second inicio rise >=1 cycle after fin low; dato=0x02 stable.

Source files
------------

// File: rtl/calc_hs_pkg.sv
// Shared types and constants for the inicio/fin four-phase handshake.
// Purpose: state encoding of the requester FSM and handshake timing constants.
// Ports: none (package); imported by requester and unit-side FSMs.
package calc_hs_pkg;

  // Requester states: idle, inicio raised, waiting for fin release, result held.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2,
    DONE = 2'd3
  } ini_estado_t;

  // Minimum number of cycles inicio stays low between two requests.
  localparam int unsigned T_INICIO_MIN_BAJO = 1;

endpackage

// File: rtl/iniciador_calculo_if.sv
// Bundle of the command bus, the inicio/fin unit link and the result bus.
// Purpose: groups every non-clock signal of the requester into one port.
// Ports: master = requester view (drives inicio/dato/results), slave = environment view.
interface iniciador_calculo_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned RES_W  = 8,
  parameter int unsigned CNT_W  = 8
);

  // command side
  logic              cmd_valid;
  logic              cmd_ready;
  logic [DATA_W-1:0] cmd_data;
  // calculation unit side
  logic              inicio;
  logic [DATA_W-1:0] dato;
  logic              fin;
  logic [RES_W-1:0]  resultado;
  // result side
  logic              res_valid;
  logic              res_ready;
  logic [RES_W-1:0]  res_data;
  logic              res_err;
  logic [CNT_W-1:0]  lat_ciclos;
  logic              ocupado;

  modport master (
    input  cmd_valid, cmd_data, fin, resultado, res_ready,
    output cmd_ready, inicio, dato, res_valid, res_data, res_err, lat_ciclos, ocupado
  );

  modport slave (
    output cmd_valid, cmd_data, fin, resultado, res_ready,
    input  cmd_ready, inicio, dato, res_valid, res_data, res_err, lat_ciclos, ocupado
  );

endinterface

// File: rtl/contador_timeout.sv
// Saturating cycle counter with a programmable expiry flag.
// Latency: cnt updates one cycle after en/clr; expira is combinational from cnt and en.
// Ports: clk, rst (async active-low), clr, en -> cnt, expira. No backpressure.
module contador_timeout #(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             expira
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  // Count value during the last allowed cycle; unused when the timeout is disabled.
  localparam logic [CNT_W-1:0] ULTIMO  = (TIMEOUT_CYC == 0) ? '0 : CNT_W'(TIMEOUT_CYC - 1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != CNT_MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expira = (TIMEOUT_CYC != 0) && en && (cnt == ULTIMO);

endmodule

// File: rtl/iniciador_calculo.sv
// Requester end of the inicio/fin four-phase handshake with timeout and latency capture.
// Latency: cmd accepted at edge t -> inicio during t+1; fin seen at f -> res_valid at f+2 (fast release).
// Backpressure: one transaction in flight; cmd_ready low outside IDLE, result held until res_ready.
// Ports: clk, rst (async active-low), bus (iniciador_calculo_if.master).
module iniciador_calculo
  import calc_hs_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned RES_W       = 8,
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned CNT_W       = 8
) (
  input logic                 clk,
  input logic                 rst,
  iniciador_calculo_if.master bus
);

  ini_estado_t estado, estado_sig;

  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  lat_sig;
  logic              expira;

  logic [DATA_W-1:0] dato_q;
  logic [RES_W-1:0]  res_data_q;
  logic              res_err_q;
  logic [CNT_W-1:0]  lat_q;

  logic              inicio_c;
  logic              cmd_ready_c;
  logic              res_valid_c;
  logic              ocupado_c;

  contador_timeout #(
    .CNT_W       (CNT_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_contador (
    .clk    (clk),
    .rst    (rst),
    .clr    (estado == IDLE),
    .en     (estado == REQ),
    .cnt    (cnt),
    .expira (expira)
  );

  // Cycles inicio has been high including the current one, saturating.
  assign lat_sig = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      estado <= IDLE;
    end else begin
      estado <= estado_sig;
    end
  end

  // Next state
  always_comb begin
    estado_sig = estado;
    case (estado)
      IDLE:    if (bus.cmd_valid)       estado_sig = REQ;
      REQ:     if (bus.fin || expira)   estado_sig = ACK;
      ACK:     if (!bus.fin)            estado_sig = DONE;
      DONE:    if (bus.res_ready)       estado_sig = IDLE;
      default:                          estado_sig = IDLE;
    endcase
  end

  // Outputs decoded from state only, so fin never reaches inicio combinationally.
  // cmd_ready is also gated by reset because the async reset parks the FSM in IDLE.
  always_comb begin
    inicio_c    = (estado == REQ);
    cmd_ready_c = rst && (estado == IDLE);
    res_valid_c = (estado == DONE);
    ocupado_c   = (estado != IDLE);
  end

  // Operand and result capture; fin takes priority over a simultaneous timeout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dato_q     <= '0;
      res_data_q <= '0;
      res_err_q  <= 1'b0;
      lat_q      <= '0;
    end else begin
      if ((estado == IDLE) && bus.cmd_valid) begin
        dato_q <= bus.cmd_data;
      end
      if (estado == REQ) begin
        if (bus.fin) begin
          res_data_q <= bus.resultado;
          res_err_q  <= 1'b0;
          lat_q      <= lat_sig;
        end else if (expira) begin
          res_data_q <= '0;
          res_err_q  <= 1'b1;
          lat_q      <= lat_sig;
        end
      end
    end
  end

  assign bus.inicio     = inicio_c;
  assign bus.cmd_ready  = cmd_ready_c;
  assign bus.res_valid  = res_valid_c;
  assign bus.ocupado    = ocupado_c;
  assign bus.dato       = dato_q;
  assign bus.res_data   = res_data_q;
  assign bus.res_err    = res_err_q;
  assign bus.lat_ciclos = lat_q;

endmodule

// File: tb/tb_iniciador_calculo.sv
// Bench for iniciador_calculo: directed and random transactions against a unit model.
// The unit raises fin after a chosen number of inicio-high cycles and releases it a chosen number of cycles late.
// Ports: none (top-level bench).
module tb_iniciador_calculo;
  import calc_hs_pkg::*;

  localparam int TO = 4;

  logic clk;
  logic rst;

  iniciador_calculo_if #(.DATA_W(8), .RES_W(8), .CNT_W(8)) bus ();

  iniciador_calculo #(
    .DATA_W      (8),
    .RES_W       (8),
    .TIMEOUT_CYC (TO),
    .CNT_W       (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Unit model: fin rises during the u_d-th inicio-high cycle, held u_rel cycles after inicio falls.
  int         u_d;
  int         u_rel;
  int         hi_cnt;
  int         hold_cnt;
  logic       fin_force;
  logic [7:0] res_val;
  logic [7:0] junk;

  assign bus.fin       = fin_force | (bus.inicio && (hi_cnt >= u_d - 1)) | (hold_cnt > 0);
  assign bus.resultado = bus.fin ? res_val : junk;

  always @(posedge clk) begin
    junk <= 8'($urandom);
    if (bus.inicio) begin
      hi_cnt <= hi_cnt + 1;
      if (bus.fin) hold_cnt <= u_rel;
    end else begin
      hi_cnt <= 0;
      if (hold_cnt > 0) hold_cnt <= hold_cnt - 1;
    end
  end

  int checks;
  int errors;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full transaction; expectations come from the handshake rules, not from the DUT.
  task automatic txn(input logic [7:0] d8, input int d, input int rel, input logic [7:0] rv, input int bp);
    int         w;
    int         hi;
    int         ack;
    int         exp_hi;
    logic       exp_err;
    logic       ok;
    logic [7:0] snap_d;
    logic       snap_e;
    logic [7:0] snap_l;
    exp_err = (d > TO);
    exp_hi  = exp_err ? TO : d;
    u_d     = d;
    u_rel   = rel;
    res_val = rv;

    w = 0;
    while (bus.cmd_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("cmd_ready_idle", 32'(bus.cmd_ready), 32'd1);

    bus.cmd_valid = 1'b1;
    bus.cmd_data  = d8;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = 8'($urandom);
    chk("inicio_rise", 32'(bus.inicio), 32'd1);

    hi = 0;
    ok = 1'b1;
    while (bus.inicio === 1'b1 && hi < 300) begin
      if (bus.dato !== d8 || bus.cmd_ready !== 1'b0 || bus.ocupado !== 1'b1 || bus.res_valid !== 1'b0)
        ok = 1'b0;
      hi++;
      @(negedge clk);
    end
    chk("dato_stable_req", 32'(ok), 32'd1);
    chk("inicio_cycles", 32'(hi), 32'(exp_hi));

    ack = 0;
    ok  = 1'b1;
    while (bus.res_valid !== 1'b1 && ack < 300) begin
      if (bus.inicio !== 1'b0 || bus.ocupado !== 1'b1 || bus.cmd_ready !== 1'b0) ok = 1'b0;
      ack++;
      @(negedge clk);
    end
    chk("ack_quiet", 32'(ok), 32'd1);
    chk("ack_cycles", 32'(ack), exp_err ? 32'd1 : 32'(rel + 1));
    chk("res_data", 32'(bus.res_data), exp_err ? 32'd0 : 32'(rv));
    chk("res_err", 32'(bus.res_err), 32'(exp_err));
    chk("lat_ciclos", 32'(bus.lat_ciclos), 32'(exp_hi));

    snap_d = bus.res_data;
    snap_e = bus.res_err;
    snap_l = bus.lat_ciclos;
    ok = 1'b1;
    for (int i = 0; i < bp; i++) begin
      fin_force = 1'($urandom);
      @(negedge clk);
      if (bus.res_valid !== 1'b1 || bus.res_data !== snap_d || bus.res_err !== snap_e ||
          bus.lat_ciclos !== snap_l || bus.cmd_ready !== 1'b0 || bus.inicio !== 1'b0)
        ok = 1'b0;
    end
    fin_force = 1'b0;
    if (bp > 0) chk("backpressure_hold", 32'(ok), 32'd1);

    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    chk("res_valid_drop", 32'(bus.res_valid), 32'd0);
    chk("cmd_ready_after", 32'(bus.cmd_ready), 32'd1);
    chk("gap_low_cycles", 32'((bus.inicio === 1'b0 && bus.fin === 1'b0) ? 1 : 0),
        32'(T_INICIO_MIN_BAJO));
  endtask

  initial begin
    logic ok;
    checks        = 0;
    errors        = 0;
    u_d           = 1000;
    u_rel         = 0;
    hi_cnt        = 0;
    hold_cnt      = 0;
    fin_force     = 1'b0;
    res_val       = 8'h00;
    junk          = 8'h00;
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = 8'h00;
    bus.res_ready = 1'b0;
    rst           = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_inicio", 32'(bus.inicio), 32'd0);
    chk("rst_dato", 32'(bus.dato), 32'd0);
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_res_data", 32'(bus.res_data), 32'd0);
    chk("rst_res_err", 32'(bus.res_err), 32'd0);
    chk("rst_lat", 32'(bus.lat_ciclos), 32'd0);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    chk("rst_ocupado", 32'(bus.ocupado), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // fin while idle must be ignored
    fin_force = 1'b1;
    ok = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (bus.ocupado !== 1'b0 || bus.inicio !== 1'b0) ok = 1'b0;
    end
    fin_force = 1'b0;
    chk("idle_fin_ignored", 32'(ok), 32'd1);

    txn(8'h2A, 3, 0, 8'h55, 0);     // nominal
    txn(8'h33, 2, 0, 8'hA5, 5);     // result backpressure
    txn(8'h44, 1000, 0, 8'hEE, 1);  // unit never answers -> timeout
    txn(8'h45, 4, 0, 8'h9C, 0);     // fin and timeout on the same cycle
    txn(8'h46, 5, 0, 8'h9D, 0);     // fin would come one cycle too late
    txn(8'h50, 2, 3, 8'h7E, 0);     // slow fin release
    txn(8'h01, 1, 0, 8'h11, 0);     // back-to-back pair
    txn(8'h02, 2, 0, 8'h22, 0);

    // async reset in the middle of REQ
    u_d   = 1000;
    u_rel = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = 8'h77;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk("mid_req_inicio", 32'(bus.inicio), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("arst_inicio", 32'(bus.inicio), 32'd0);
    chk("arst_ocupado", 32'(bus.ocupado), 32'd0);
    chk("arst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    chk("arst_dato", 32'(bus.dato), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    ok = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (bus.res_valid !== 1'b0 || bus.inicio !== 1'b0) ok = 1'b0;
    end
    chk("arst_no_result", 32'(ok), 32'd1);
    chk("arst_idle_ready", 32'(bus.cmd_ready), 32'd1);

    for (int n = 0; n < 25; n++) begin
      txn(8'($urandom), int'($urandom_range(1, 6)), int'($urandom_range(0, 3)),
          8'($urandom), int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

endmodule
